// File: rtl/mpdmac_fifo_pkg.sv
// Shared types and helpers for the multi-port DMAC data FIFO.
package mpdmac_fifo_pkg;

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic afull;
    logic empty;
    logic aempty;
    logic ovf;
    logic udf;
  } fifo_status_t;

endpackage

// File: rtl/mpdmac_fifo_mem.sv
// 1W1R register-array storage for the DMAC FIFO; asynchronous (show-ahead) read port.
module mpdmac_fifo_mem #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the pointers alone decide which words are valid,
  // and leaving the array unreset lets it map onto plain flops or LUT-RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mpdmac_fifo_ctrl.sv
// Per-channel DMAC data FIFO: pointers, occupancy, threshold flags, sticky errors.
// Optional high-watermark output hwm_o is enabled by defining MPDMAC_FIFO_STATS_EN.
module mpdmac_fifo_ctrl
  import mpdmac_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = fifo_cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [CNT_W-1:0]      afull_thr_i,
  input  logic [CNT_W-1:0]      aempty_thr_i,
  input  logic                  wren_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  full_o,
  output logic                  afull_o,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  empty_o,
  output logic                  aempty_o,
  output logic [CNT_W-1:0]      count_o,
  input  logic                  err_clr_i,
`ifdef MPDMAC_FIFO_STATS_EN
  output logic [CNT_W-1:0]      hwm_o,
`endif
  output logic                  ovf_o,
  output logic                  udf_o
);

  localparam int AW = CNT_W - 1;

  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  fifo_status_t     st_q, st_d;
  logic             wr_acc, rd_acc;

  // NOTE: every always_comb output gets a default at the top, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_acc   = wren_i & ~st_q.full  & ~flush_i;
    rd_acc   = rden_i & ~st_q.empty & ~flush_i;
    wr_ptr_d = wr_ptr_q + CNT_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + CNT_W'(rd_acc);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    // Pointers wrap modulo 2*FIFO_DEPTH == 2**CNT_W, so the difference is the occupancy.
    count_d     = wr_ptr_d - rd_ptr_d;
    st_d.full   = (wr_ptr_d[CNT_W-1] != rd_ptr_d[CNT_W-1]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    st_d.empty  = (wr_ptr_d == rd_ptr_d);
    st_d.afull  = (count_d >= afull_thr_i);
    st_d.aempty = (count_d <= aempty_thr_i);
    // Set beats clear; a flush cycle never flags an error.
    st_d.ovf    = (wren_i & st_q.full  & ~flush_i) | (st_q.ovf & ~err_clr_i);
    st_d.udf    = (rden_i & st_q.empty & ~flush_i) | (st_q.udf & ~err_clr_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // count 0 is <= any unsigned threshold, so aempty is always set out of reset.
      st_q     <= '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1,
                    ovf: 1'b0, udf: 1'b0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      st_q     <= st_d;
    end
  end

`ifdef MPDMAC_FIFO_STATS_EN
  logic [CNT_W-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    if (flush_i || err_clr_i) hwm_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm_o = hwm_q;
`endif

  mpdmac_fifo_mem #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata_o)
  );

  assign full_o   = st_q.full;
  // A zero threshold is met even by an empty FIFO, including straight out of reset.
  assign afull_o  = st_q.afull | (afull_thr_i == '0);
  assign empty_o  = st_q.empty;
  assign aempty_o = st_q.aempty;
  assign count_o  = count_q;
  assign ovf_o    = st_q.ovf;
  assign udf_o    = st_q.udf;

endmodule

// File: tb/tb_mpdmac_fifo_ctrl.sv
// Self-checking bench for mpdmac_fifo_ctrl against a queue-based reference model.
module tb_mpdmac_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int DW    = 32;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush_i, wren_i, rden_i, err_clr_i;
  logic [CW-1:0] afull_thr, aempty_thr;
  logic [DW-1:0] wdata_i, rdata_o;
  logic          full_o, afull_o, empty_o, aempty_o, ovf_o, udf_o;
  logic [CW-1:0] count_o;
`ifdef MPDMAC_FIFO_STATS_EN
  logic [CW-1:0] hwm_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO contents as a queue plus sticky flags.
  logic [DW-1:0] m_q[$];
  bit            m_ovf, m_udf;
  int            m_hwm;

  always #5 clk = ~clk;

  mpdmac_fifo_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .afull_thr_i  (afull_thr),
    .aempty_thr_i (aempty_thr),
    .wren_i       (wren_i),
    .wdata_i      (wdata_i),
    .full_o       (full_o),
    .afull_o      (afull_o),
    .rden_i       (rden_i),
    .rdata_o      (rdata_o),
    .empty_o      (empty_o),
    .aempty_o     (aempty_o),
    .count_o      (count_o),
    .err_clr_i    (err_clr_i),
`ifdef MPDMAC_FIFO_STATS_EN
    .hwm_o        (hwm_o),
`endif
    .ovf_o        (ovf_o),
    .udf_o        (udf_o)
  );

  task automatic model_step(input bit fl, input bit wr, input logic [DW-1:0] wd,
                            input bit rd, input bit clr);
    bit was_full  = (m_q.size() == DEPTH);
    bit was_empty = (m_q.size() == 0);
    if (fl) m_q.delete();
    else begin
      if (rd && !was_empty) void'(m_q.pop_front());
      if (wr && !was_full)  m_q.push_back(wd);
    end
    m_ovf = (!fl && wr && was_full)  || (m_ovf && !clr);
    m_udf = (!fl && rd && was_empty) || (m_udf && !clr);
    if (fl || clr) m_hwm = m_q.size();
    else if (m_q.size() > m_hwm) m_hwm = m_q.size();
  endtask

  // Apply one cycle of inputs, advance the model, and sample 1 time unit after the edge.
  task automatic drive(input bit fl, input bit wr, input logic [DW-1:0] wd,
                       input bit rd, input bit clr);
    flush_i = fl; wren_i = wr; wdata_i = wd; rden_i = rd; err_clr_i = clr;
    model_step(fl, wr, wd, rd, clr);
    @(posedge clk);
    #1;
    flush_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0; err_clr_i = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_hwm = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    model_reset();
    n_vec++; if (count_o !== '0)   begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty_o); end
    n_vec++; if (full_o !== 1'b0)  begin n_err++; $display("FAIL reset_full got %b want 0", full_o); end
    n_vec++; if (aempty_o !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b want 1", aempty_o); end
    n_vec++; if (afull_o !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", afull_o); end
    n_vec++; if ({ovf_o, udf_o} !== 2'b00) begin n_err++; $display("FAIL reset_err got %b%b want 00", ovf_o, udf_o); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, DW'(32'h1000 + i), 1'b0, 1'b0);
      n_vec++; if (count_o !== CW'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count_o, i + 1); end
      n_vec++; if (afull_o !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull_o, i + 1 >= 12); end
      n_vec++; if (full_o !== (i + 1 == DEPTH)) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", i, full_o, i + 1 == DEPTH); end
      n_vec++; if (aempty_o !== (i + 1 <= 2)) begin n_err++; $display("FAIL fill_aempty[%0d] got %b want %b", i, aempty_o, i + 1 <= 2); end
    end
    n_vec++; if (rdata_o !== 32'h1000) begin n_err++; $display("FAIL fill_head got %h want 00001000", rdata_o); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) begin
        n_vec++; if (rdata_o !== DW'(32'h1000 + i)) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, rdata_o, 32'h1000 + i); end
      end
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      n_vec++; if (empty_o !== (i >= DEPTH - 1)) begin n_err++; $display("FAIL drain_empty[%0d] got %b want %b", i, empty_o, i >= DEPTH - 1); end
    end
    n_vec++; if (udf_o !== 1'b1) begin n_err++; $display("FAIL drain_udf got %b want 1", udf_o); end
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL drain_count got %0d want 0", count_o); end
    n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL drain_ovf got %b want 0", ovf_o); end
  endtask

  task automatic test_full_rw();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, DW'(32'h1000 + i), 1'b0, 1'b0);
    drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    n_vec++; if (count_o !== CW'(15)) begin n_err++; $display("FAIL fullrw_count got %0d want 15", count_o); end
    n_vec++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL fullrw_ovf got %b want 1", ovf_o); end
    n_vec++; if (udf_o !== 1'b0) begin n_err++; $display("FAIL fullrw_udf got %b want 0", udf_o); end
    n_vec++; if (rdata_o !== 32'h1001) begin n_err++; $display("FAIL fullrw_head got %h want 00001001", rdata_o); end
    n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL fullrw_full got %b want 0", full_o); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] head = m_q[0];
      n_vec++; if (rdata_o !== head) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", i, rdata_o, head); end
      drive(1'b0, 1'b1, DW'($urandom), 1'b1, 1'b0);
      n_vec++; if (count_o !== CW'(5)) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 5", i, count_o); end
      n_vec++; if ({full_o, empty_o} !== 2'b00) begin n_err++; $display("FAIL wrap_flags[%0d] got full=%b empty=%b want 00", i, full_o, empty_o); end
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, DW'($urandom), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 32'h5555_5555, 1'b0, 1'b0);
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL flush_count got %0d want 0", count_o); end
    n_vec++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL flush_empty got %b want 1", empty_o); end
    n_vec++; if ({ovf_o, udf_o} !== 2'b00) begin n_err++; $display("FAIL flush_err got %b%b want 00", ovf_o, udf_o); end
    drive(1'b0, 1'b1, 32'h0000_ABCD, 1'b0, 1'b0);
    n_vec++; if (rdata_o !== 32'h0000_ABCD) begin n_err++; $display("FAIL flush_wr_data got %h want 0000abcd", rdata_o); end
    n_vec++; if ({empty_o, count_o} !== {1'b0, CW'(1)}) begin n_err++; $display("FAIL flush_wr_state got empty=%b count=%0d want 0/1", empty_o, count_o); end
  endtask

`ifdef MPDMAC_FIFO_STATS_EN
  task automatic test_stats();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, DW'(i), 1'b0, 1'b0);
    n_vec++; if (hwm_o !== CW'(7)) begin n_err++; $display("FAIL stats_hwm_burst got %0d want 7", hwm_o); end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    n_vec++; if (hwm_o !== CW'(7)) begin n_err++; $display("FAIL stats_hwm_hold got %0d want 7", hwm_o); end
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    n_vec++; if (hwm_o !== CW'(4)) begin n_err++; $display("FAIL stats_hwm_clr got %0d want 4", hwm_o); end
  endtask
`endif

  task automatic test_async_reset();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, DW'(32'h7000 + i), 1'b0, 1'b0);
    n_vec++; if (count_o !== CW'(7)) begin n_err++; $display("FAIL arst_pre_count got %0d want 7", count_o); end
    wren_i = 1'b1; wdata_i = 32'h7007;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL arst_count got %0d want 0", count_o); end
    n_vec++; if ({empty_o, full_o, aempty_o} !== 3'b101) begin n_err++; $display("FAIL arst_flags got e=%b f=%b ae=%b want 1/0/1", empty_o, full_o, aempty_o); end
    n_vec++; if ({ovf_o, udf_o} !== 2'b00) begin n_err++; $display("FAIL arst_err got %b%b want 00", ovf_o, udf_o); end
`ifdef MPDMAC_FIFO_STATS_EN
    n_vec++; if (hwm_o !== '0) begin n_err++; $display("FAIL arst_hwm got %0d want 0", hwm_o); end
`endif
    wren_i = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int  p_wr = ((i / 75) % 2 == 0) ? 80 : 30;
      bit  fl   = ($urandom_range(63) == 0);
      bit  clr  = ($urandom_range(15) == 0);
      bit  wr   = ($urandom_range(99) < p_wr);
      bit  rd   = ($urandom_range(99) < 55);
      if (i % 100 == 0) begin
        afull_thr  = CW'($urandom_range(31));
        aempty_thr = CW'($urandom_range(31));
      end
      drive(fl, wr, DW'($urandom), rd, clr);
      n_vec++; if (count_o !== CW'(m_q.size())) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count_o, m_q.size()); end
      n_vec++; if (full_o !== (m_q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full[%0d] got %b", i, full_o); end
      n_vec++; if (empty_o !== (m_q.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d] got %b", i, empty_o); end
      n_vec++; if (afull_o !== (m_q.size() >= int'(afull_thr))) begin n_err++; $display("FAIL rnd_afull[%0d] got %b thr=%0d cnt=%0d", i, afull_o, afull_thr, m_q.size()); end
      n_vec++; if (aempty_o !== (m_q.size() <= int'(aempty_thr))) begin n_err++; $display("FAIL rnd_aempty[%0d] got %b thr=%0d cnt=%0d", i, aempty_o, aempty_thr, m_q.size()); end
      n_vec++; if ({ovf_o, udf_o} !== {m_ovf, m_udf}) begin n_err++; $display("FAIL rnd_err[%0d] got %b%b want %b%b", i, ovf_o, udf_o, m_ovf, m_udf); end
      if (m_q.size() != 0) begin
        logic [DW-1:0] head = m_q[0];
        n_vec++; if (rdata_o !== head) begin n_err++; $display("FAIL rnd_data[%0d] got %h want %h", i, rdata_o, head); end
      end
`ifdef MPDMAC_FIFO_STATS_EN
      n_vec++; if (hwm_o !== CW'(m_hwm)) begin n_err++; $display("FAIL rnd_hwm[%0d] got %0d want %0d", i, hwm_o, m_hwm); end
`endif
    end
  endtask

  initial begin
    flush_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0; err_clr_i = 1'b0;
    wdata_i = '0; afull_thr = CW'(12); aempty_thr = CW'(2);
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_wrap();
    test_flush();
`ifdef MPDMAC_FIFO_STATS_EN
    test_stats();
`endif
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
